boot_loader_ctrl: RTL and testbench
===================================

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory word-address width (legal range 8..12).
REQ-002 SHALL have parameter TIMEOUT, default 100000, meaning the inter-byte timeout in clk cycles (legal range >= 2).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx_data, input, 8, a received UART byte.
REQ-006 SHALL have port rx_valid, input, 1, a one-cycle strobe marking rx_data valid.
REQ-007 SHALL have port tx_data, output, 8, the status byte to transmit.
REQ-008 SHALL have port tx_valid, output, 1, marking tx_data valid.
REQ-009 SHALL have port tx_ready, input, 1, the UART transmitter accepting the byte.
REQ-010 SHALL have port imem_we, output, 1, the instruction-memory write strobe.
REQ-011 SHALL have port imem_addr, output, ADDR_W, the instruction-memory word address.
REQ-012 SHALL have port imem_wdata, output, 32, the instruction word to write.
REQ-013 SHALL have port cpu_reset, output, 1, holding the pipeline in reset.
REQ-014 SHALL have port load_done, output, 1, high once a load has completed and the pipeline is released.
REQ-015 SHALL have port error, output, 1, sticky: timeout or checksum failure.

Function
REQ-016 SHALL implement states IDLE, LEN, DATA, CSUM, ACK and RUN.
REQ-017 IDLE: rx_valid with rx_data = 0xA5 SHALL go to LEN; any other byte SHALL be dropped.
REQ-018 LEN: the next byte SHALL be latched as word count N; N = 0 SHALL go directly to ACK with status OK; otherwise go to DATA.
REQ-019 DATA: bytes SHALL assemble little-endian, first byte into bits [7:0]; on the 4th byte, imem_we SHALL pulse for exactly 1 cycle in the next cycle, carrying imem_wdata and imem_addr.
REQ-020 imem_addr SHALL start at 0 for each load and increment by 1 after each write; after N writes the FSM SHALL go to CSUM (macro set) or ACK (macro clear).
REQ-021 ACK: tx_valid SHALL stay high with tx_data = 0x4B (OK) or 0x45 (error) until the cycle tx_ready = 1.
REQ-022 On the ACK handshake with status OK, the FSM SHALL go to RUN; with status error, it SHALL go to IDLE.
REQ-023 rx_valid in ACK SHALL be ignored.
REQ-024 RUN: cpu_reset = 0 and load_done = 1.
REQ-025 In RUN, byte 0xA5 SHALL reassert cpu_reset in the next cycle, clear load_done, and go to LEN (reprogram); other bytes SHALL be ignored.
REQ-026 Inter-byte timeout: the counter SHALL run only in LEN, DATA and CSUM, and SHALL clear on every rx_valid.
REQ-027 When the counter reaches TIMEOUT, the FSM SHALL set error, discard the partial word, and go to IDLE, keeping cpu_reset = 1.
REQ-028 If rx_valid coincides with the timeout cycle, the byte SHALL win and the timeout SHALL not fire.
REQ-029 cpu_reset SHALL be 1 in every state except RUN.
REQ-030 error SHALL be cleared only by reset or by a subsequent successful ACK.

Reset
REQ-031 On reset, the following SHALL be forced immediately and asynchronously: state = IDLE, cpu_reset = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, tx_valid = 0, tx_data = 0, load_done = 0, error = 0, byte/word/timeout counters = 0.
REQ-032 Reset asserted mid-load SHALL abandon the load; words already written SHALL remain in memory.

Configuration
REQ-033 Macro BOOT_LOADER_CHECKSUM_EN SHALL control the checksum feature.
REQ-034 With BOOT_LOADER_CHECKSUM_EN defined: CSUM SHALL receive one byte, compared against the modulo-256 sum of all 4N data bytes; mismatch SHALL give status error (0x45), set error, and route ACK to IDLE; N = 0 SHALL skip CSUM.
REQ-035 Without BOOT_LOADER_CHECKSUM_EN: the CSUM state and sum register SHALL be absent; DATA SHALL proceed directly to ACK with OK.

Verification
REQ-036 Sequence A5 01 13 00 00 00 (plus checksum 13 if the macro is defined) -> one imem_we pulse with addr 0 and wdata 0x00000013; tx 0x4B; cpu_reset falls after the handshake.
REQ-037 Sequence A5 02 followed by 8 bytes -> writes at addr 0 and 1; the second word is little-endian correct; load_done = 1.
REQ-038 Sequence A5 02 followed by 3 bytes, then silence for TIMEOUT cycles -> error = 1, state IDLE, no partial write, cpu_reset stays 1.
REQ-039 With the macro defined, sequence A5 01 01 02 03 04 0B -> checksum mismatch (expected 0A): tx 0x45, error = 1, cpu_reset stays 1.
REQ-040 In RUN, a 0xA5 byte -> cpu_reset = 1 next cycle; a new load of N = 1 writes addr 0 again.
REQ-041 Hold tx_ready = 0 for 50 cycles in ACK -> tx_valid stays high with stable tx_data; rx bytes ignored; RUN entered on the ready cycle.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// UART boot loader: sync byte 0xA5, word count, little-endian words to imem, optional checksum, status ack.
// Latency: imem write one cycle after the 4th byte; ack held until tx_ready; optional BOOT_LOADER_CHECKSUM_EN.
// Backpressure: none on rx (strobe input); tx_valid/tx_data hold until tx_ready, rx ignored meanwhile.
module boot_loader_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM = 3'd3;
`endif
    localparam logic [2:0] S_ACK  = 3'd4;
    localparam logic [2:0] S_RUN  = 3'd5;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ST_OK     = 8'h4B;
    localparam logic [7:0] ST_ERR    = 8'h45;

    logic [2:0]        state;
    logic [7:0]        word_total;
    logic [7:0]        word_cnt;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_buf;
    logic [ADDR_W-1:0] next_addr;
    logic [TW-1:0]     tcnt;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    logic timing_state;
    logic timeout_hit;

`ifdef BOOT_LOADER_CHECKSUM_EN
    assign timing_state = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
`else
    assign timing_state = (state == S_LEN) || (state == S_DATA);
`endif
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout_hit = timing_state && !rx_valid && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cpu_reset  <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            load_done  <= 1'b0;
            error      <= 1'b0;
            word_total <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            next_addr  <= '0;
            tcnt       <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            imem_we <= 1'b0;

            if (timing_state && !rx_valid && !timeout_hit)
                tcnt <= tcnt + TW'(1);
            else
                tcnt <= '0;

            if (timeout_hit) begin
                error    <= 1'b1;
                byte_cnt <= '0;
                word_buf <= '0;
                state    <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            state     <= S_LEN;
                            next_addr <= '0;
                            word_cnt  <= '0;
                            byte_cnt  <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                            sum       <= '0;
`endif
                        end
                    end

                    S_LEN: begin
                        if (rx_valid) begin
                            word_total <= rx_data;
                            if (rx_data == 8'd0) begin
                                state    <= S_ACK;
                                tx_valid <= 1'b1;
                                tx_data  <= ST_OK;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end

                    S_DATA: begin
                        if (rx_valid) begin
                            byte_cnt <= byte_cnt + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                            sum      <= sum + rx_data;
`endif
                            case (byte_cnt)
                                2'd0: word_buf[7:0]   <= rx_data;
                                2'd1: word_buf[15:8]  <= rx_data;
                                2'd2: word_buf[23:16] <= rx_data;
                                default: begin
                                    imem_we    <= 1'b1;
                                    imem_wdata <= {rx_data, word_buf};
                                    imem_addr  <= next_addr;
                                    next_addr  <= next_addr + ADDR_W'(1);
                                    word_cnt   <= word_cnt + 8'd1;
                                    if (word_cnt == word_total - 8'd1) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                                        state    <= S_CSUM;
`else
                                        state    <= S_ACK;
                                        tx_valid <= 1'b1;
                                        tx_data  <= ST_OK;
`endif
                                    end
                                end
                            endcase
                        end
                    end

`ifdef BOOT_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (rx_valid) begin
                            state    <= S_ACK;
                            tx_valid <= 1'b1;
                            if (rx_data == sum) begin
                                tx_data <= ST_OK;
                            end else begin
                                tx_data <= ST_ERR;
                                error   <= 1'b1;
                            end
                        end
                    end
`endif

                    S_ACK: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            if (tx_data == ST_OK) begin
                                state     <= S_RUN;
                                cpu_reset <= 1'b0;
                                load_done <= 1'b1;
                                error     <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end

                    S_RUN: begin
                        // Sync byte while running restarts a load with the core held in reset.
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            state     <= S_LEN;
                            cpu_reset <= 1'b1;
                            load_done <= 1'b0;
                            next_addr <= '0;
                            word_cnt  <= '0;
                            byte_cnt  <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                            sum       <= '0;
`endif
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: loads, reprogram, ack backpressure, timeouts, reset mid-load, checksum.
module tb_boot_loader_ctrl;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        error;

    int checks = 0;
    int errors = 0;

    int          wr_n = 0;
    logic [7:0]  wr_addr [0:15];
    logic [31:0] wr_data [0:15];

    boot_loader_ctrl #(.ADDR_W(8), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Log every cycle imem_we is high; a stretched pulse shows up as an extra write.
    always @(posedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] <= imem_addr;
                wr_data[wr_n] <= imem_wdata;
            end
            wr_n <= wr_n + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // All tasks are entered and left at a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_ack(input logic [7:0] exp, input int hold, input string name);
        int n = 0;
        logic unstable = 1'b0;
        while (tx_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s ack_valid: tx_valid=%b required 1", name, tx_valid);
        end
        checks++;
        if (tx_data !== exp) begin
            errors++;
            $display("FAIL %s ack_data: tx_data=%h required %h", name, tx_data, exp);
        end
        checks++;
        if (cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL %s ack_cpu_reset: cpu_reset=%b required 1", name, cpu_reset);
        end
        for (int i = 0; i < hold; i++) begin
            tx_ready = 1'b0;
            rx_valid = (i == hold / 2);
            rx_data  = (i == hold / 2) ? 8'hA5 : 8'h00;
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== exp) unstable = 1'b1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        checks++;
        if (unstable !== 1'b0) begin
            errors++;
            $display("FAIL %s ack_hold: tx_valid=%b tx_data=%h required 1/%h throughout", name, tx_valid, tx_data, exp);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s ack_release: tx_valid=%b required 0", name, tx_valid);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: %b required 1", cpu_reset); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_imem_we: %b required 0", imem_we); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rst_imem_addr: %h required 00", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL rst_imem_wdata: %h required 0", imem_wdata); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: %b required 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: %h required 00", tx_data); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done: %b required 0", load_done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: %b required 0", error); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word;
        int base = wr_n;
        send_byte(8'h11);
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h13);
`endif
        wait_ack(8'h4B, 0, "single");
        checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL single_wr_count: %0d required 1", wr_n - base); end
        checks++; if (wr_addr[base] !== 8'h00) begin errors++; $display("FAIL single_addr: %h required 00", wr_addr[base]); end
        checks++; if (wr_data[base] !== 32'h00000013) begin errors++; $display("FAIL single_wdata: %h required 00000013", wr_data[base]); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL single_cpu_reset: %b required 0", cpu_reset); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL single_load_done: %b required 1", load_done); end
    endtask

    task automatic test_reprogram_backpressure;
        int base;
        send_byte(8'h33);
        checks++; if (cpu_reset !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL run_ignore: cpu_reset=%b load_done=%b required 0/1", cpu_reset, load_done); end
        send_byte(8'hA5);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reprog_cpu_reset: %b required 1", cpu_reset); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reprog_load_done: %b required 0", load_done); end
        base = wr_n;
        send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h64);
`endif
        wait_ack(8'h4B, 50, "two_word");
        checks++; if (wr_n - base !== 2) begin errors++; $display("FAIL two_wr_count: %0d required 2", wr_n - base); end
        checks++; if (wr_addr[base] !== 8'h00 || wr_data[base] !== 32'h44332211) begin errors++; $display("FAIL two_word0: addr %h data %h required 00 44332211", wr_addr[base], wr_data[base]); end
        checks++; if (wr_addr[base+1] !== 8'h01 || wr_data[base+1] !== 32'h88776655) begin errors++; $display("FAIL two_word1: addr %h data %h required 01 88776655", wr_addr[base+1], wr_data[base+1]); end
        checks++; if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL two_run: load_done=%b cpu_reset=%b required 1/0", load_done, cpu_reset); end
    endtask

    task automatic test_timeout_byte_wins;
        send_byte(8'hA5);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h00);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL edge_byte_wins: error=%b required 0", error); end
        wait_ack(8'h4B, 0, "edge_ok");
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL edge_run: cpu_reset=%b required 0", cpu_reset); end
    endtask

    task automatic test_timeout_data;
        int base = wr_n;
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        repeat (TO + 5) @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL tmo_error: %b required 1", error); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL tmo_cpu_reset: %b required 1", cpu_reset); end
        checks++; if (wr_n - base !== 0) begin errors++; $display("FAIL tmo_no_write: %0d writes required 0", wr_n - base); end
        checks++; if (load_done !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL tmo_outputs: load_done=%b tx_valid=%b required 0/0", load_done, tx_valid); end
        send_byte(8'hA5); send_byte(8'h00);
        wait_ack(8'h4B, 0, "tmo_recover");
        checks++; if (error !== 1'b0 || cpu_reset !== 1'b0) begin errors++; $display("FAIL tmo_recover: error=%b cpu_reset=%b required 0/0", error, cpu_reset); end
    endtask

    task automatic test_timeout_exact;
        send_byte(8'hA5);
        repeat (TO - 1) @(negedge clk);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL tmo_early: error=%b required 0 at TIMEOUT-1", error); end
        @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL tmo_exact: error=%b required 1 at TIMEOUT", error); end
        send_byte(8'hA5); send_byte(8'h00);
        wait_ack(8'h4B, 0, "exact_recover");
    endtask

    task automatic test_reset_midload;
        int base = wr_n;
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_byte(8'hEE);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL arst_ctrl: cpu_reset=%b load_done=%b required 1/0", cpu_reset, load_done); end
        checks++; if (imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin errors++; $display("FAIL arst_imem: addr=%h wdata=%h required 00/0", imem_addr, imem_wdata); end
        checks++; if (wr_n - base !== 1 || wr_data[base] !== 32'hDDCCBBAA) begin errors++; $display("FAIL arst_kept_word: n=%0d data=%h required 1 DDCCBBAA", wr_n - base, wr_data[base]); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'hA5); send_byte(8'h00);
        wait_ack(8'h4B, 0, "after_arst");
    endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad;
        int base = wr_n;
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0B);
        wait_ack(8'h45, 3, "csum_bad");
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL csum_error: %b required 1", error); end
        checks++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL csum_hold: cpu_reset=%b load_done=%b required 1/0", cpu_reset, load_done); end
        checks++; if (wr_data[base] !== 32'h04030201) begin errors++; $display("FAIL csum_word: %h required 04030201", wr_data[base]); end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        test_reset;
        test_single_word;
        test_reprogram_backpressure;
        test_timeout_byte_wins;
        test_timeout_data;
        test_timeout_exact;
        test_reset_midload;
`ifdef BOOT_LOADER_CHECKSUM_EN
        test_checksum_bad;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
